// File: rtl/cnn_frame_feeder.sv
// Frame feeder in front of the CNN: buffers one host frame, replays it at a paced rate,
// then captures and holds the classifier result. Optional result timeout: CNN_FEEDER_TIMEOUT_EN.
module cnn_frame_feeder #(
  parameter int DATA_WIDTH     = 8,
  parameter int IMG_WIDTH      = 28,
  parameter int IMG_HEIGHT     = 28,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  cnn_valid,
  input  logic [3:0]            cnn_class,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [3:0]            res_class,
  output logic                  res_err,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {LOAD, STREAM, WAIT_RES, REPORT} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  rd_done_q, rd_done_d;
  logic                  last_q, last_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [DATA_WIDTH-1:0] pix_data_q;
  logic [3:0]            res_class_q, res_class_d;
  logic                  res_err_q, res_err_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  wr_en, rd_en;
  logic                  timeout;

  logic [DATA_WIDTH-1:0] mem [N];

`ifdef CNN_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_q, wait_d;

  // Counter sits at zero outside WAIT_RES, so entry always starts from 0.
  always_comb begin
    wait_d = '0;
    if (state_q == WAIT_RES) wait_d = wait_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  assign timeout = (wait_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    gap_d       = gap_q;
    rd_done_d   = rd_done_q;
    last_d      = last_q;
    pix_valid_d = 1'b0;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    frame_cnt_d = frame_cnt_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (addr_q == LAST) begin
            addr_d    = '0;
            gap_d     = '0;
            rd_done_d = 1'b0;
            last_d    = 1'b0;
            state_d   = STREAM;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      STREAM: begin
        // One read per pixel slot; the gap counter paces the slots.
        if (!rd_done_q) begin
          if (gap_q == '0) begin
            rd_en       = 1'b1;
            pix_valid_d = 1'b1;
            last_d      = (addr_q == LAST);
            gap_d       = GW'(GAP_CYCLES);
            if (addr_q == LAST) begin
              rd_done_d = 1'b1;
              addr_d    = '0;
            end else begin
              addr_d = addr_q + AW'(1);
            end
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        // Leave only once the final pixel has actually been presented.
        if (pix_valid_q && last_q) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (cnn_valid) begin
          res_class_d = cnn_class;
          res_err_d   = 1'b0;
          state_d     = REPORT;
        end else if (timeout) begin
          res_class_d = '0;
          res_err_d   = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          res_err_d   = 1'b0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      addr_q      <= '0;
      gap_q       <= '0;
      rd_done_q   <= 1'b0;
      last_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      gap_q       <= gap_d;
      rd_done_q   <= rd_done_d;
      last_q      <= last_d;
      pix_valid_q <= pix_valid_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
      frame_cnt_q <= frame_cnt_d;
      if (rd_en) pix_data_q <= mem[addr_q];
    end
  end

  // Single-port frame store: written only in LOAD, read only in STREAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= s_data;
  end

  assign s_ready   = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign res_valid = (state_q == REPORT);
  assign res_class = res_class_q;
  assign res_err   = res_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Self-checking bench for cnn_frame_feeder: a default 28x28 instance and a 4x4 GAP=2 instance,
// checked against a frame-array reference of load/stream/result behaviour.
module tb_cnn_frame_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  bit         sel;
  logic       s_valid;
  logic [7:0] s_data;
  logic       cnn_valid;
  logic [3:0] cnn_class;
  logic       res_ready;

  logic       a_s_ready, a_pix_valid, a_res_valid, a_res_err, a_busy;
  logic [7:0] a_pix_data;
  logic [3:0] a_res_class;
  logic [15:0] a_frame_cnt;
  logic       b_s_ready, b_pix_valid, b_res_valid, b_res_err, b_busy;
  logic [7:0] b_pix_data;
  logic [3:0] b_res_class;
  logic [15:0] b_frame_cnt;

  cnn_frame_feeder dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sel ? 1'b0 : s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .pix_valid(a_pix_valid), .pix_data(a_pix_data),
    .cnn_valid(sel ? 1'b0 : cnn_valid), .cnn_class(cnn_class),
    .res_valid(a_res_valid), .res_ready(sel ? 1'b0 : res_ready),
    .res_class(a_res_class), .res_err(a_res_err), .busy(a_busy), .frame_cnt(a_frame_cnt)
  );

  cnn_frame_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sel ? s_valid : 1'b0), .s_ready(b_s_ready), .s_data(s_data),
    .pix_valid(b_pix_valid), .pix_data(b_pix_data),
    .cnn_valid(sel ? cnn_valid : 1'b0), .cnn_class(cnn_class),
    .res_valid(b_res_valid), .res_ready(sel ? res_ready : 1'b0),
    .res_class(b_res_class), .res_err(b_res_err), .busy(b_busy), .frame_cnt(b_frame_cnt)
  );

  logic        v_s_ready, v_pix_valid, v_res_valid, v_res_err, v_busy;
  logic [7:0]  v_pix_data;
  logic [3:0]  v_res_class;
  logic [15:0] v_frame_cnt;
  assign v_s_ready   = sel ? b_s_ready   : a_s_ready;
  assign v_pix_valid = sel ? b_pix_valid : a_pix_valid;
  assign v_pix_data  = sel ? b_pix_data  : a_pix_data;
  assign v_res_valid = sel ? b_res_valid : a_res_valid;
  assign v_res_class = sel ? b_res_class : a_res_class;
  assign v_res_err   = sel ? b_res_err   : a_res_err;
  assign v_busy      = sel ? b_busy      : a_busy;
  assign v_frame_cnt = sel ? b_frame_cnt : a_frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] frame [784];
  int n;
  int gap;
  int exp_frames;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < n; i++) frame[i] = 8'($urandom);
  endtask

  // Push frame[0..n-1] through the host port; ends in the cycle after the last accept.
  task automatic load_frame(input bit bubbles, input int poke_at);
    int i = 0;
    int cyc = 0;
    int bad = 0;
    bit acc;
    while (i < n && cyc < 8 * n) begin
      s_valid   = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data    = s_valid ? frame[i] : 8'($urandom);
      cnn_valid = (cyc == poke_at);
      cnn_class = 4'd5;
      if (v_s_ready !== 1'b1 || v_pix_valid !== 1'b0 || v_busy !== 1'b0) bad++;
      acc = s_valid && v_s_ready;
      step();
      if (acc) i++;
      cyc++;
    end
    s_valid = 1'b0;
    cnn_valid = 1'b0;
    checks++;
    if (i != n) begin errors++; $display("FAIL load_count: accepted %0d required %0d", i, n); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL load_outputs: bad cycles %0d required 0", bad); end
    checks++;
    if (v_s_ready !== 1'b0) begin errors++; $display("FAIL s_ready_drop: got %b required 0", v_s_ready); end
    checks++;
    if (v_busy !== 1'b1) begin errors++; $display("FAIL busy_stream: got %b required 1", v_busy); end
  endtask

  // Expected: pixel j presented at relative cycle 1 + j*(gap+1); ends in first WAIT_RES cycle.
  task automatic stream_check(input int poke_at);
    int total = n + (n - 1) * gap;
    int bad = 0;
    int pulses = 0;
    bit exp_v;
    checks++;
    if (v_pix_valid !== 1'b0) begin errors++; $display("FAIL pix_valid_c1: got %b required 0", v_pix_valid); end
    for (int k = 1; k <= total; k++) begin
      cnn_valid = (k == poke_at);
      cnn_class = 4'd5;
      step();
      exp_v = (((k - 1) % (gap + 1)) == 0);
      if (v_pix_valid !== exp_v) bad++;
      else if (exp_v && v_pix_data !== frame[(k - 1) / (gap + 1)]) bad++;
      if (v_s_ready !== 1'b0 || v_res_valid !== 1'b0 || v_busy !== 1'b1) bad++;
      if (v_pix_valid === 1'b1) pulses++;
    end
    cnn_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stream: bad cycles %0d required 0", bad); end
    checks++;
    if (pulses != n) begin errors++; $display("FAIL stream_pulses: got %0d required %0d", pulses, n); end
    step();
    checks++;
    if (v_pix_valid !== 1'b0 || v_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: pix_valid %b res_valid %b required 0 0", v_pix_valid, v_res_valid);
    end
  endtask

  task automatic result_phase(input int pre_wait, input logic [3:0] cls, input logic [3:0] cls2, input int hold);
    int bad = 0;
    for (int k = 0; k < pre_wait; k++) begin
      if (v_res_valid !== 1'b0 || v_busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wait_idle: bad cycles %0d required 0", bad); end
    cnn_valid = 1'b1;
    cnn_class = cls;
    step();
    cnn_class = cls2;
    checks++;
    if (v_res_valid !== 1'b1 || v_res_class !== cls || v_res_err !== 1'b0) begin
      errors++;
      $display("FAIL result_capture: valid %b class %0d err %b required 1 %0d 0", v_res_valid, v_res_class, v_res_err, cls);
    end
    step();
    cnn_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      res_ready = 1'b0;
      if (v_res_valid !== 1'b1 || v_res_class !== cls || v_res_err !== 1'b0 || v_s_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL result_hold: bad cycles %0d required 0", bad); end
    res_ready = 1'b1;
    checks++;
    if (v_res_valid !== 1'b1 || v_res_class !== cls) begin
      errors++;
      $display("FAIL result_before_ack: valid %b class %0d required 1 %0d", v_res_valid, v_res_class, cls);
    end
    step();
    res_ready = 1'b0;
    exp_frames = (exp_frames + 1) & 16'hFFFF;
    checks++;
    if (v_frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL frame_cnt: got %0d required %0d", v_frame_cnt, exp_frames);
    end
    checks++;
    if (v_s_ready !== 1'b1 || v_res_valid !== 1'b0 || v_res_err !== 1'b0 || v_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_ack: s_ready %b res_valid %b res_err %b busy %b required 1 0 0 0",
               v_s_ready, v_res_valid, v_res_err, v_busy);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (v_s_ready !== 1'b1 || v_pix_valid !== 1'b0 || v_pix_data !== 8'd0 || v_res_valid !== 1'b0 ||
        v_res_class !== 4'd0 || v_res_err !== 1'b0 || v_busy !== 1'b0 || v_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: s_ready %b pix_valid %b pix_data %0h res_valid %b class %0d err %b busy %b cnt %0d required 1 0 0 0 0 0 0 0",
               tag, v_s_ready, v_pix_valid, v_pix_data, v_res_valid, v_res_class, v_res_err, v_busy, v_frame_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0;
    check_reset_values("reset_a");
    sel = 1'b1;
    #0 check_reset_values("reset_b");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_frames = 0;
  endtask

  task automatic test_stream_ramp();
    for (int i = 0; i < n; i++) frame[i] = 8'(i % 256);
    load_frame(1'b0, -1);
    stream_check(-1);
    result_phase(0, 4'd7, 4'd3, 10);
  endtask

  task automatic test_ignored_cnn();
    fill_random();
    load_frame(1'b1, 100);
    stream_check(400);
    result_phase(5, 4'd2, 4'd11, 3);
  endtask

  task automatic test_midreset();
    fill_random();
    load_frame(1'b0, -1);
    for (int k = 1; k <= 301; k++) step();
    checks++;
    if (v_pix_valid !== 1'b1 || v_pix_data !== frame[300]) begin
      errors++;
      $display("FAIL pixel300: valid %b data %0h required 1 %0h", v_pix_valid, v_pix_data, frame[300]);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_frames = 0;
    fill_random();
    load_frame(1'b1, -1);
    stream_check(-1);
    result_phase(2, 4'($urandom), 4'($urandom), 1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      fill_random();
      load_frame(1'b1, -1);
      stream_check(-1);
      result_phase($urandom_range(0, 4), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_gap();
    sel = 1'b1;
    n = 16;
    gap = 2;
    #0;
    exp_frames = 0;
    fill_random();
    load_frame(1'b1, -1);
    stream_check(-1);
  endtask

  task automatic test_timeout();
    int bad = 0;
`ifdef CNN_FEEDER_TIMEOUT_EN
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k < 50 && v_res_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_early: bad cycles %0d required 0", bad); end
    checks++;
    if (v_res_valid !== 1'b1 || v_res_err !== 1'b1 || v_res_class !== 4'd0) begin
      errors++;
      $display("FAIL timeout_report: valid %b err %b class %0d required 1 1 0", v_res_valid, v_res_err, v_res_class);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (v_frame_cnt !== 16'd1 || v_res_err !== 1'b0 || v_s_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ack: cnt %0d err %b s_ready %b required 1 0 1", v_frame_cnt, v_res_err, v_s_ready);
    end
`else
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (v_res_valid !== 1'b0 || v_busy !== 1'b1 || v_res_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_timeout: bad cycles %0d required 0", bad); end
    result_phase(0, 4'd9, 4'd1, 2);
`endif
  endtask

  initial begin
    sel = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    cnn_valid = 1'b0;
    cnn_class = '0;
    res_ready = 1'b0;
    n = 784;
    gap = 0;
    exp_frames = 0;
    test_reset();
    test_stream_ramp();
    test_ignored_cnn();
    test_midreset();
    test_back_to_back();
    test_gap();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_frame_feeder.md
Name: cnn_frame_feeder

Overview:
Upstream front end of the cnn top. Accepts a host byte stream (valid/ready), buffers one full IMG_WIDTH x IMG_HEIGHT frame, then replays it to cnn.valid_in/pixel_in at a controlled rate. It then waits for the classifier result and holds it on a result handshake port until the host takes it. Only one frame is in flight at a time, which keeps the downstream line buffers and flatten buffer from being overrun.

Parameters:
DATA_WIDTH, 8, pixel width
IMG_WIDTH, 28, pixels per row
IMG_HEIGHT, 28, rows per frame
GAP_CYCLES, 0, idle cycles inserted after every streamed pixel (0 = back-to-back)
TIMEOUT_CYCLES, 200000, max cycles in WAIT_RES before the result is abandoned (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  host pixel valid
s_ready  out  1  feeder can accept pixel
s_data  in  DATA_WIDTH  host pixel, raster order
pix_valid  out  1  to cnn valid_in
pix_data  out  DATA_WIDTH  to cnn pixel_in
cnn_valid  in  1  from cnn valid_out
cnn_class  in  4  from cnn class_out
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_class  out  4  captured class
res_err  out  1  1 = timeout, class invalid (always 0 without optional feature)
busy  out  1  high in any state except LOAD
frame_cnt  out  16  completed result handshakes, wraps 0xFFFF->0

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. All outputs reset to 0 except s_ready, which resets to 1. State resets to LOAD and counters to 0. Buffer contents are not reset. A reset in mid-operation aborts the frame; the next accepted pixel is pixel 0.
- N = IMG_WIDTH*IMG_HEIGHT. Buffer depth is N x DATA_WIDTH, single port, synchronous read.
- LOAD:
  - s_ready = 1. A pixel is accepted when s_valid && s_ready and is written at wr_ptr, which then increments.
  - When pixel N-1 is accepted: s_ready drops the next cycle, wr_ptr clears, state -> STREAM.
- STREAM:
  - Pixels are read in index order 0..N-1. pix_data is registered.
  - The first pix_valid goes high 2 cycles after the cycle in which pixel N-1 was accepted.
  - Each pixel is held for exactly 1 cycle with pix_valid=1, followed by GAP_CYCLES cycles with pix_valid=0. No gap follows the last pixel.
  - Total STREAM duration is N + (N-1)*GAP_CYCLES valid/gap cycles.
  - pix_data is don't-care when pix_valid=0 and is held at the last value.
  - After pixel N-1 is presented: state -> WAIT_RES.
- WAIT_RES:
  - The first cycle with cnn_valid=1 captures cnn_class into res_class. State -> REPORT and res_valid=1 from the next cycle.
  - cnn_valid in LOAD or STREAM is ignored and has no state effect.
- REPORT:
  - res_valid, res_class and res_err stay stable until res_valid && res_ready.
  - On that cycle: frame_cnt increments, then next cycle res_valid=0, res_err=0, s_ready=1, state -> LOAD.
  - cnn_valid in REPORT is ignored; the first captured value wins.
- A result handshake and a new pixel are never accepted in the same cycle, because s_ready=0 until LOAD.
- Invariants: pix_valid is never high outside STREAM; s_ready is never high outside LOAD.

Optional Feature:
- Macro: CNN_FEEDER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT_RES and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES-1 with no cnn_valid: res_class=0, res_err=1, state -> REPORT.
  - If cnn_valid arrives on that same cycle, the valid result wins and res_err=0.
- Not defined: no counter is built; WAIT_RES waits indefinitely; res_err is tied to 0.

Test Plan:
- Default params, stream pixels 0..783 mod 256 with s_valid always high -> s_ready low after pixel 783. pix_valid high for 784 consecutive cycles starting 2 cycles later, pix_data = 0,1,..,255,0,..,15 in order.
- GAP_CYCLES=2, IMG 4x4 -> 16 valid pulses, each separated by exactly 2 low cycles, 46 cycles total. Random s_valid bubbles during LOAD produce no lost or duplicated pixel.
- After the stream, pulse cnn_valid with cnn_class=7, then again with 3; hold res_ready=0 for 10 cycles -> res_valid=1, res_class=7 stable. Raising res_ready gives frame_cnt=1 and s_ready=1 the next cycle.
- Pulse cnn_valid with class 5 during LOAD and during STREAM -> ignored; the later WAIT_RES pulse with class 2 is reported as 2.
- Assert rst_n low midway through STREAM (pixel 300) -> all outputs at reset values immediately. A new full frame then streams from pixel 0 correctly.
- CNN_FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=50, no cnn_valid -> res_valid=1, res_err=1, res_class=0 exactly 50 cycles after entering WAIT_RES. Without the macro, still waiting at 1000 cycles.
